// File: rtl/vote_pkg.sv
// Shared definitions for the four-voter ballot controller.
package vote_pkg;

    localparam int unsigned NUM_VOTERS = 4;

    // Bit positions inside the one-hot {pass, tie, fail} result vector.
    localparam int unsigned PASS = 2;
    localparam int unsigned TIE  = 1;
    localparam int unsigned FAIL = 0;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        TALLY,
        DONE
    } vote_state_e;

endpackage

// File: rtl/vote_ctrl_if.sv
// Ballot handshake bundle between the controller and its client.
interface vote_ctrl_if;
    import vote_pkg::*;

    logic                  start;
    logic [NUM_VOTERS-1:0] vote_valid;
    logic [NUM_VOTERS-1:0] vote_yes;
    logic [NUM_VOTERS-1:0] vote_ack;
    logic                  busy;
    logic [2:0]            result;
    logic                  result_valid;
    logic [NUM_VOTERS-1:0] abstain;

    modport master (
        output start, vote_valid, vote_yes,
        input  vote_ack, busy, result, result_valid, abstain
    );

    modport slave (
        input  start, vote_valid, vote_yes,
        output vote_ack, busy, result, result_valid, abstain
    );

endinterface

// File: rtl/voter_if.sv
// Combinational yes-count decoder: O[3]=pass (>=3), O[2]=tie (==2), O[1]=fail (<=1).
module voter_if (
    input  logic [3:0] I,
    output logic [3:1] O
);

    logic [2:0] n_yes;

    // Count yes votes and classify the outcome.
    always_comb begin
        n_yes = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            n_yes = n_yes + 3'(I[k]);
        end
        O[3] = (n_yes >= 3'd3);
        O[2] = (n_yes == 3'd2);
        O[1] = (n_yes <= 3'd1);
    end

endmodule

// File: rtl/vote_ctrl.sv
// Four-voter ballot controller: collects one vote per voter until all have
// voted or the timeout expires, then reports a one-hot pass/tie/fail result.
module vote_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    vote_ctrl_if.slave  bus
);

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    vote_state_e           state;
    logic [CW-1:0]         cnt;
    logic [NUM_VOTERS-1:0] yes_q;
    logic [NUM_VOTERS-1:0] voted_q;
    logic [NUM_VOTERS-1:0] accept;
    logic [NUM_VOTERS-1:0] tally_in;
    logic [3:1]            tally_out;

    // Votes are only taken from voters that have not voted yet this ballot.
    always_comb begin
        accept = bus.vote_valid & ~voted_q;
    end

    // The decoder sees the latched choices only during TALLY.
    always_comb begin
        tally_in = (state == TALLY) ? yes_q : '0;
    end

    voter_if u_voter_if (
        .I (tally_in),
        .O (tally_out)
    );

    // Ballot FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            yes_q            <= '0;
            voted_q          <= '0;
            bus.vote_ack     <= '0;
            bus.busy         <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.abstain      <= '0;
        end else begin
            bus.vote_ack     <= '0;
            bus.result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        yes_q    <= '0;
                        voted_q  <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A vote landing on the timeout cycle is still latched.
                    voted_q      <= voted_q | accept;
                    yes_q        <= (yes_q & ~accept) | (bus.vote_yes & accept);
                    bus.vote_ack <= accept;
                    cnt          <= cnt + CW'(1);
                    if ((&voted_q) || (cnt == CNT_LAST)) begin
                        state <= TALLY;
                    end
                end
                TALLY: begin
                    bus.result[PASS] <= tally_out[3];
                    bus.result[TIE]  <= tally_out[2];
                    bus.result[FAIL] <= tally_out[1];
                    bus.abstain      <= ~voted_q;
                    bus.result_valid <= 1'b1;
                    state            <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vote_ctrl.md
VOTE_CTRL -- requirements
Module: vote_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the number of COLLECT cycles allowed before an incomplete ballot closes (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  a one-cycle pulse that opens a ballot.
REQ-005 The block SHALL have port vote_valid  input  4  bit k set means voter k presents a vote this cycle.
REQ-006 The block SHALL have port vote_yes  input  4  bit k is voter k's choice (1 = yes), qualified by vote_valid[k].
REQ-007 The block SHALL have port vote_ack  output  4  a registered one-cycle pulse on bit k the cycle after voter k's vote is accepted.
REQ-008 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 The block SHALL have port result  output  3  {pass, tie, fail}, one-hot; held until the next start is accepted.
REQ-010 The block SHALL have port result_valid  output  1  a one-cycle pulse when result updates.
REQ-011 The block SHALL have port abstain  output  4  bit k set means voter k did not vote in the last ballot; updated with result.

Function
REQ-012 The FSM SHALL have states IDLE, COLLECT, TALLY and DONE.
REQ-013 In IDLE, start=1 SHALL clear the yes/voted registers and the timeout counter, then enter COLLECT on the next cycle.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 vote_valid SHALL be ignored in IDLE, TALLY and DONE, and no ack SHALL be issued in those states.
REQ-016 In COLLECT, vote_valid[k]=1 with voted[k]=0 SHALL set voted[k], latch yes[k]=vote_yes[k], and pulse vote_ack[k] on the next cycle.
REQ-017 Multiple voters SHALL be accepted in the same cycle.
REQ-018 A repeat vote from voter k (voted[k]=1) SHALL be ignored: no ack, and yes[k] is unchanged.
REQ-019 The timeout counter SHALL increment once per COLLECT cycle, starting at 0.
REQ-020 COLLECT SHALL exit to TALLY on the cycle after all four voted bits are set, or after the counter reaches TIMEOUT-1, whichever comes first.
REQ-021 A vote arriving in the same cycle as the timeout SHALL be accepted.
REQ-022 Non-voters SHALL count as no: yes[k] remains 0.
REQ-023 TALLY SHALL last one cycle and drive yes[3:0] into the voter_if instance.
REQ-024 voter_if SHALL decode as follows: O[3]=pass (3 or more yes), O[2]=tie (exactly 2 yes), O[1]=fail (1 or fewer yes).
REQ-025 At the end of TALLY, the block SHALL register O into result and ~voted into abstain.
REQ-026 DONE SHALL last one cycle with result_valid=1, then return to IDLE.
REQ-027 Latency SHALL be: result_valid occurs 2 cycles after the COLLECT exit condition.
REQ-028 The minimum start-to-result_valid latency SHALL be 4 cycles (all votes in the first COLLECT cycle).

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE and clear the counter, yes and voted registers.
REQ-030 Reset SHALL force vote_ack=0, busy=0, result=3'b000, result_valid=0 and abstain=4'b0000.
REQ-031 Reset asserted mid-ballot SHALL discard the ballot without producing result_valid.
REQ-032 After rst_n deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-033 Package vote_pkg SHALL hold the state enum, NUM_VOTERS=4, and the result bit indices PASS=2, TIE=1, FAIL=0.
REQ-034 vote_ctrl SHALL instantiate exactly one sub-module, voter_if (combinational, I[3:0] to O[3:1]).
REQ-035 The counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-036 Scenario: start, then vote_valid=4'b1111 with vote_yes=4'b1011 in one cycle -> vote_ack=4'b1111 next cycle; result=3'b100; abstain=4'b0000; result_valid 4 cycles after start was sampled.
REQ-037 Scenario: start, then votes from voters 0 and 1 only, both yes; TIMEOUT=16 -> exit after 16 COLLECT cycles; result=3'b010 (tie); abstain=4'b1100.
REQ-038 Scenario: voter 2 votes yes, then votes no two cycles later -> a single ack; yes[2] remains 1.
REQ-039 Scenario: start pulsed in COLLECT, and vote_valid=4'b1111 in IDLE -> both ignored: no ack, state unchanged.
REQ-040 Scenario: rst_n pulled low after 2 votes in COLLECT -> busy=0 and result=3'b000 immediately; no result_valid; the next ballot starts clean.
REQ-041 Scenario: TIMEOUT=1 with a vote landing on the timeout cycle -> vote accepted and included in the tally.
